// File: rtl/rtc_bus_engine_pkg.sv
// Shared definitions for the RTC multiplexed-bus engine: state encoding,
// default phase length and the RTC register map.
package rtc_bus_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_STB,
    ST_A_HLD,
    ST_D_STB,
    ST_D_HLD,
    ST_DONE
  } state_t;

  // 100 ns per bus phase at a 100 MHz system clock
  localparam int T_PH_DEFAULT = 10;

  localparam logic [7:0] ADDR_SECONDS = 8'h20;
  localparam logic [7:0] ADDR_MINUTES = 8'h21;
  localparam logic [7:0] ADDR_HOURS   = 8'h22;
  localparam logic [7:0] ADDR_DATE    = 8'h23;
  localparam logic [7:0] ADDR_MONTH   = 8'h24;
  localparam logic [7:0] ADDR_YEAR    = 8'h25;
  localparam logic [7:0] ADDR_TIMER   = 8'h26;
  localparam logic [7:0] ADDR_COMMAND = 8'h27;

endpackage

// File: rtl/rtc_bus_engine.sv
// Single-transfer engine for an RTC with a multiplexed address/data bus:
// address strobe, address hold, data strobe, data hold, then a done pulse.
module rtc_bus_engine
  import rtc_bus_engine_pkg::*;
#(
  parameter int T_PH = T_PH_DEFAULT  // legal range 2..255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       cs_n,
  output logic       ad_sel,
  output logic       rd_n,
  output logic       wr_n
);

  localparam int CW = (T_PH > 1) ? $clog2(T_PH) : 1;
  localparam logic [CW-1:0] LAST = CW'(T_PH - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            rw_q, rw_nxt;
  logic [7:0]      addr_q, addr_nxt;
  logic [7:0]      wdata_q, wdata_nxt;

  logic            cs_n_nxt, ad_sel_nxt, rd_n_nxt, wr_n_nxt, ad_oe_nxt;
  logic            busy_nxt, done_nxt;
  logic [7:0]      ad_out_nxt, rdata_nxt;
  logic            phase_end;

  assign phase_end = (cnt == LAST);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    rw_nxt    = rw_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_A_STB;
          rw_nxt    = rw;
          addr_nxt  = addr;
          wdata_nxt = wdata;
        end
      end
      ST_A_STB: if (phase_end) state_nxt = ST_A_HLD;
      ST_A_HLD: if (phase_end) state_nxt = ST_D_STB;
      ST_D_STB: if (phase_end) state_nxt = ST_D_HLD;
      ST_D_HLD: if (phase_end) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    cnt_nxt = (state_nxt != state || state == ST_IDLE) ? '0 : cnt + 1'b1;

    // Outputs are decoded from the next state so the registered pins line up
    // with the state they describe.
    cs_n_nxt   = 1'b1;
    ad_sel_nxt = 1'b0;
    rd_n_nxt   = 1'b1;
    wr_n_nxt   = 1'b1;
    ad_oe_nxt  = 1'b0;
    ad_out_nxt = 8'h00;
    busy_nxt   = (state_nxt != ST_IDLE);
    done_nxt   = (state_nxt == ST_DONE);

    unique case (state_nxt)
      ST_A_STB: begin
        cs_n_nxt   = 1'b0;
        wr_n_nxt   = 1'b0;
        ad_oe_nxt  = 1'b1;
        ad_out_nxt = addr_nxt;
      end
      ST_A_HLD: begin
        cs_n_nxt   = 1'b0;
        ad_oe_nxt  = 1'b1;
        ad_out_nxt = addr_nxt;
      end
      ST_D_STB: begin
        cs_n_nxt   = 1'b0;
        ad_sel_nxt = 1'b1;
        if (rw_nxt) begin
          rd_n_nxt = 1'b0;
        end else begin
          wr_n_nxt   = 1'b0;
          ad_oe_nxt  = 1'b1;
          ad_out_nxt = wdata_nxt;
        end
      end
      ST_D_HLD: begin
        cs_n_nxt   = 1'b0;
        ad_sel_nxt = 1'b1;
        if (!rw_nxt) begin
          ad_oe_nxt  = 1'b1;
          ad_out_nxt = wdata_nxt;
        end
      end
      default: ;
    endcase

    // Read data is taken only on the final cycle of the data strobe.
    rdata_nxt = (state == ST_D_STB && phase_end && rw_q) ? ad_in : rdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rw_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      cs_n    <= 1'b1;
      ad_sel  <= 1'b0;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      ad_oe   <= 1'b0;
      ad_out  <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rw_q    <= rw_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      cs_n    <= cs_n_nxt;
      ad_sel  <= ad_sel_nxt;
      rd_n    <= rd_n_nxt;
      wr_n    <= wr_n_nxt;
      ad_oe   <= ad_oe_nxt;
      ad_out  <= ad_out_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      rdata   <= rdata_nxt;
    end
  end

endmodule

// File: doc/rtc_bus_engine.md
RTC_BUS_ENGINE -- requirements
Module: rtc_bus_engine

Interface
REQ-001 Parameter T_PH, default 10, clocks per bus phase (100 ns at 100 MHz); legal range 2..255.
REQ-002 clock  in  1  system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 start  in  1  one-cycle request; sampled only in IDLE.
REQ-005 rw  in  1  1 = read, 0 = write; captured with start.
REQ-006 addr  in  8  RTC register address; captured with start.
REQ-007 wdata  in  8  write byte; captured with start.
REQ-008 busy  out  1  high from the cycle after start until DONE inclusive.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 rdata  out  8  last read byte; holds until next read completes.
REQ-011 ad_out  out  8  multiplexed address/data bus drive value.
REQ-012 ad_oe  out  1  1 = drive ad_out onto the pad; 0 = tri-state.
REQ-013 ad_in  in  8  pad input, synchronous to clock.
REQ-014 cs_n, ad_sel, rd_n, wr_n  out  1 each  RTC strobes; ad_sel 0 = address cycle, 1 = data cycle.

Function
REQ-015 FSM states: IDLE, A_STB, A_HLD, D_STB, D_HLD, DONE; one phase counter shared by all timed states.
REQ-016 IDLE: cs_n=1, rd_n=1, wr_n=1, ad_sel=0, ad_oe=0, busy=0; start=1 -> capture rw/addr/wdata, go to A_STB, counter=0.
REQ-017 A_STB (T_PH cycles): cs_n=0, ad_sel=0, wr_n=0, ad_oe=1, ad_out=addr.
REQ-018 A_HLD (T_PH cycles): cs_n=0, wr_n=1, ad_oe=1, ad_out=addr held.
REQ-019 D_STB (T_PH cycles): cs_n=0, ad_sel=1; write: wr_n=0, ad_oe=1, ad_out=wdata; read: rd_n=0, ad_oe=0.
REQ-020 Read: rdata loads ad_in on the last D_STB cycle (counter = T_PH-1) only.
REQ-021 D_HLD (T_PH cycles): rd_n=1, wr_n=1, cs_n=0; write keeps ad_oe=1 and ad_out=wdata; read keeps ad_oe=0.
REQ-022 DONE (1 cycle): cs_n=1, ad_oe=0, done=1, busy=1; next state IDLE.
REQ-023 Each timed state exits when counter = T_PH-1; counter clears on every state change; counter width = clog2(T_PH).
REQ-024 Latency: done asserts exactly 4*T_PH+1 cycles after the start cycle (41 at default).
REQ-025 start in any state other than IDLE, including DONE, is ignored; no queuing.
REQ-026 rd_n and wr_n are never low together; ad_oe never 1 while rd_n=0.
REQ-027 All outputs registered; no combinational path from inputs to outputs.
REQ-028 Captured rw/addr/wdata are immune to input changes after start.

Reset
REQ-029 reset=0 forces state IDLE, counter=0, cs_n=1, rd_n=1, wr_n=1, ad_sel=0, ad_oe=0, ad_out=0, busy=0, done=0, rdata=0.
REQ-030 Reset mid-transaction aborts it on the next edge; no done pulse; rdata not updated.
REQ-031 First start accepted is the first one sampled with reset=1 in IDLE.

Structure
REQ-032 Shared package holds state encoding, T_PH default, and RTC register address constants (seconds, minutes, hours, date, month, year, timer, command).
REQ-033 Single module; no sub-module, pad tri-state resolved at top level from ad_oe.
REQ-034 Target size 120-250 lines RTL.

Verification
REQ-035 Write: start, rw=0, addr=0x21, wdata=0x45 -> wr_n low cycles 1-10 with ad_out=0x21, ad_sel=0; wr_n low cycles 21-30 with ad_out=0x45, ad_sel=1; done at cycle 41.
REQ-036 Read: start, rw=1, addr=0x22, ad_in=0x13 -> rd_n low cycles 21-30, ad_oe=0 there, rdata=0x13 after cycle 30, done at 41.
REQ-037 Start pulses at cycles 5 and 41 of an active transaction -> both ignored, exactly one done.
REQ-038 reset=0 at cycle 25 of a read -> next edge all strobes high, ad_oe=0, no done, rdata unchanged.
REQ-039 T_PH=2 build: back-to-back write then read -> each done at 9 cycles after its start; rd_n and wr_n never simultaneously low.
REQ-040 Read with ad_in changing from 0xAA to 0x55 at D_STB last cycle -> rdata=0x55; change after that cycle -> no effect.
